issue_ctrl: RTL and testbench
=============================

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have parameter OPB_W, default `CIRNO_DEC_OPB_SIZE, width of operation bus.
REQ-002 SHALL have parameter SELE_W, default `CIRNO_DEC_USELE, width of unit-select bus (ALU/BJU/LSU one-hot).
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have decode-side ports: i_dec_valid in 1; o_dec_ready out 1; i_opb in OPB_W; i_usele in SELE_W; i_rs1_ren, i_rs2_ren in 1; i_rs1_idx, i_rs2_idx, i_rd_idx in 5; i_im in 32; i_pc in 32; i_ilgl in 1.
REQ-005 SHALL have issue-side ports: o_iss_valid out 1; o_iss_sele out SELE_W; o_iss_opb out OPB_W; o_iss_rs1_idx, o_iss_rs2_idx, o_iss_rd_idx out 5; o_iss_im, o_iss_pc out 32; i_alu_ready, i_bju_ready, i_lsu_ready in 1.
REQ-006 SHALL have control ports: i_wb_valid in 1, i_wb_rd_idx in 5 (writeback retires pending rd); i_flush in 1 (redirect kill); o_trap out 1 (illegal-instruction pulse); i_trap_ack in 1; o_busy out 1 (issue register occupied or TRAP).

Function
REQ-007 SHALL hold one issue register (IR); decode transfer occurs when i_dec_valid & o_dec_ready; issue transfer (fire) when o_iss_valid & ready of unit selected by o_iss_sele.
REQ-008 SHALL drive o_dec_ready = (state != TRAP) & ~i_flush & (IR empty | fire); back-to-back issue one per cycle with no bubble.
REQ-009 SHALL implement FSM RUN (IR empty or issuing), STALL (IR full, not firing), TRAP (illegal pending ack).
REQ-010 Transitions: RUN->STALL when IR full and no fire; STALL->RUN on fire with no new capture; any->TRAP when IR holds ilgl entry; TRAP->RUN on i_trap_ack or i_flush; any->RUN with IR empty on i_flush.
REQ-011 SHALL keep a 32-bit scoreboard SB; bit 0 permanently 0.
REQ-012 rd_wen = ALU | (LSU & ~(LSU_SB|LSU_SH|LSU_SW)) | (BJU & (BJU_JAL|BJU_JALR|BJU_AUIP)) using `CIRNO_DEC_* bit macros on IR opb.
REQ-013 On fire with rd_wen and rd!=0, SHALL set SB[rd] next cycle.
REQ-014 On i_wb_valid with i_wb_rd_idx!=0, SHALL clear SB[i_wb_rd_idx]; same-cycle set and clear of same index: set wins.
REQ-015 Hazard = (rs1_ren & SB[rs1]) | (rs2_ren & SB[rs2]) | (rd_wen & SB[rd]) on registered SB; no writeback bypass, a clear in cycle N enables issue in N+1.
REQ-016 o_iss_valid = IR full & ~ilgl & ~hazard & (state != TRAP) & ~i_flush; o_iss_* SHALL be IR contents, stable while o_iss_valid & ~ready.
REQ-017 o_iss_sele SHALL be IR usele; an IR entry with usele == 0 and ~ilgl SHALL be discarded in one cycle without issue or SB update.
REQ-018 Illegal entry in IR: no issue, o_trap high exactly one cycle on TRAP entry, IR cleared, SB unchanged.
REQ-019 i_flush SHALL empty IR, suppress same-cycle fire and capture, leave SB unchanged; flush dominates trap_ack and decode valid.
REQ-020 Ready inputs of unselected units SHALL be ignored.

Reset
REQ-021 On rst_n low, asynchronously: state RUN, IR empty, SB all 0, o_iss_valid 0, o_trap 0, o_busy 0, o_iss_* data 0; o_dec_ready 1 in first cycle after release.
REQ-022 Reset mid-operation SHALL drop IR and SB contents with no trap pulse.

Verification
REQ-023 lw x5 then add x6,x5,x1, lsu/alu ready=1 -> lw fires cycle 1, SB[5]=1, add stalls; wb rd=5 at cycle 4 -> add fires cycle 5.
REQ-024 Four addi x1..x4 back-to-back, alu ready=1 -> one fire per cycle, o_dec_ready constant 1, SB bits 1-4 set.
REQ-025 addi x0 with ALU ready=0 for 3 cycles -> o_iss_valid held, data stable, state STALL, fires cycle 4, SB[0]=0.
REQ-026 i_ilgl=1 entry -> o_trap one-cycle pulse, o_dec_ready 0 until i_trap_ack, no fire.
REQ-027 IR stalled on hazard, i_flush=1 -> IR empty next cycle, o_iss_valid 0, SB unchanged.
REQ-028 Same cycle fire of addi x7 and wb rd=7 -> SB[7]=1 after edge.

Source files
------------

// File: rtl/issue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_ctrl
//
// Purpose: single-entry issue stage between decode and the execution units
// (ALU / BJU / LSU). One issue register (IR) buffers a decoded instruction. It
// issues to the unit selected by its one-hot unit-select field once no
// scoreboard hazard is present. A 32-entry scoreboard tracks destination
// registers that have issued but not yet written back. Illegal instructions
// raise a one-cycle trap pulse and hold decode off until acknowledged.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   i_dec_valid/o_dec_ready decode handshake
//   i_opb, i_usele          operation bus, unit select (ALU/BJU/LSU one-hot)
//   i_rs1_ren, i_rs2_ren    source read enables
//   i_rs1/rs2/rd_idx        register indices
//   i_im, i_pc, i_ilgl      immediate, pc, illegal-instruction flag
//   o_iss_valid, o_iss_*    issue-side request and IR contents
//   i_alu/bju/lsu_ready     per-unit ready (only the selected one matters)
//   i_wb_valid, i_wb_rd_idx writeback retiring a pending rd
//   i_flush                 redirect kill (empties IR, leaves scoreboard)
//   o_trap, i_trap_ack      illegal-instruction pulse and acknowledge
//   o_busy                  IR occupied or trap pending
// -----------------------------------------------------------------------------

`ifndef CIRNO_DEC_OPB_SIZE
`define CIRNO_DEC_OPB_SIZE 6
`endif
`ifndef CIRNO_DEC_USELE
`define CIRNO_DEC_USELE 3
`endif
// unit-select bit positions
`ifndef CIRNO_DEC_ALU
`define CIRNO_DEC_ALU 0
`endif
`ifndef CIRNO_DEC_BJU
`define CIRNO_DEC_BJU 1
`endif
`ifndef CIRNO_DEC_LSU
`define CIRNO_DEC_LSU 2
`endif
// operation-bus bit positions (meaning depends on the selected unit)
`ifndef CIRNO_DEC_LSU_SB
`define CIRNO_DEC_LSU_SB 0
`endif
`ifndef CIRNO_DEC_LSU_SH
`define CIRNO_DEC_LSU_SH 1
`endif
`ifndef CIRNO_DEC_LSU_SW
`define CIRNO_DEC_LSU_SW 2
`endif
`ifndef CIRNO_DEC_BJU_JAL
`define CIRNO_DEC_BJU_JAL 3
`endif
`ifndef CIRNO_DEC_BJU_JALR
`define CIRNO_DEC_BJU_JALR 4
`endif
`ifndef CIRNO_DEC_BJU_AUIP
`define CIRNO_DEC_BJU_AUIP 5
`endif

// State table
//   state    | meaning
//   ST_RUN   | IR empty, or IR issuing this cycle
//   ST_STALL | IR full and not issuing (hazard or unit not ready)
//   ST_TRAP  | illegal instruction seen, waiting for i_trap_ack / i_flush
module issue_ctrl #(
    parameter int OPB_W  = `CIRNO_DEC_OPB_SIZE,
    parameter int SELE_W = `CIRNO_DEC_USELE
) (
    input  logic              clk,
    input  logic              rst_n,
    // decode side
    input  logic              i_dec_valid,
    output logic              o_dec_ready,
    input  logic [OPB_W-1:0]  i_opb,
    input  logic [SELE_W-1:0] i_usele,
    input  logic              i_rs1_ren,
    input  logic              i_rs2_ren,
    input  logic [4:0]        i_rs1_idx,
    input  logic [4:0]        i_rs2_idx,
    input  logic [4:0]        i_rd_idx,
    input  logic [31:0]       i_im,
    input  logic [31:0]       i_pc,
    input  logic              i_ilgl,
    // issue side
    output logic              o_iss_valid,
    output logic [SELE_W-1:0] o_iss_sele,
    output logic [OPB_W-1:0]  o_iss_opb,
    output logic [4:0]        o_iss_rs1_idx,
    output logic [4:0]        o_iss_rs2_idx,
    output logic [4:0]        o_iss_rd_idx,
    output logic [31:0]       o_iss_im,
    output logic [31:0]       o_iss_pc,
    input  logic              i_alu_ready,
    input  logic              i_bju_ready,
    input  logic              i_lsu_ready,
    // control
    input  logic              i_wb_valid,
    input  logic [4:0]        i_wb_rd_idx,
    input  logic              i_flush,
    output logic              o_trap,
    input  logic              i_trap_ack,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // issue register
    logic              ir_vld;
    logic              ir_ilgl;
    logic              ir_rs1_ren;
    logic              ir_rs2_ren;
    logic [OPB_W-1:0]  ir_opb;
    logic [SELE_W-1:0] ir_usele;
    logic [4:0]        ir_rs1;
    logic [4:0]        ir_rs2;
    logic [4:0]        ir_rd;
    logic [31:0]       ir_im;
    logic [31:0]       ir_pc;

    logic [31:0]       sb;
    logic [31:0]       sb_nxt;
    logic [31:0]       sb_set;
    logic [31:0]       sb_clr;
    logic              trap_q;

    logic              in_trap;
    logic              sel_ready;
    logic              rd_wen;
    logic              hazard;
    logic              iss_valid;
    logic              fire;
    logic              discard;
    logic              take_trap;
    logic              dec_ready;
    logic              capture;

    always_comb begin
        in_trap   = (state == ST_TRAP);
        sel_ready = (ir_usele[`CIRNO_DEC_ALU] & i_alu_ready)
                  | (ir_usele[`CIRNO_DEC_BJU] & i_bju_ready)
                  | (ir_usele[`CIRNO_DEC_LSU] & i_lsu_ready);

        rd_wen = ir_usele[`CIRNO_DEC_ALU]
               | (ir_usele[`CIRNO_DEC_LSU]
                  & ~(ir_opb[`CIRNO_DEC_LSU_SB] | ir_opb[`CIRNO_DEC_LSU_SH]
                      | ir_opb[`CIRNO_DEC_LSU_SW]))
               | (ir_usele[`CIRNO_DEC_BJU]
                  & (ir_opb[`CIRNO_DEC_BJU_JAL] | ir_opb[`CIRNO_DEC_BJU_JALR]
                     | ir_opb[`CIRNO_DEC_BJU_AUIP]));

        // Registered scoreboard only: a writeback clears the bit at the edge,
        // so the dependent instruction issues the cycle after.
        hazard = (ir_rs1_ren & sb[ir_rs1])
               | (ir_rs2_ren & sb[ir_rs2])
               | (rd_wen & sb[ir_rd]);

        // An entry with no unit selected is never presented as valid.
        iss_valid = ir_vld & ~ir_ilgl & ~hazard & ~in_trap & ~i_flush & (|ir_usele);
        fire      = iss_valid & sel_ready;
        discard   = ir_vld & ~ir_ilgl & ~(|ir_usele) & ~i_flush;
        take_trap = ir_vld & ir_ilgl & ~in_trap & ~i_flush;
        dec_ready = ~in_trap & ~i_flush & (~ir_vld | fire);
        capture   = i_dec_valid & dec_ready;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (take_trap)
                        state_nxt = ST_TRAP;
                    else if (ir_vld & ~fire & ~discard)
                        state_nxt = ST_STALL;
                end
                ST_STALL: begin
                    if (take_trap)
                        state_nxt = ST_TRAP;
                    else if ((fire & ~capture) | discard)
                        state_nxt = ST_RUN;
                end
                ST_TRAP: begin
                    if (i_trap_ack)
                        state_nxt = ST_RUN;
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            trap_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            trap_q <= take_trap;
        end
    end

    // issue register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_vld     <= 1'b0;
            ir_ilgl    <= 1'b0;
            ir_rs1_ren <= 1'b0;
            ir_rs2_ren <= 1'b0;
            ir_opb     <= '0;
            ir_usele   <= '0;
            ir_rs1     <= '0;
            ir_rs2     <= '0;
            ir_rd      <= '0;
            ir_im      <= '0;
            ir_pc      <= '0;
        end else if (i_flush) begin
            ir_vld <= 1'b0;
        end else if (capture) begin
            ir_vld     <= 1'b1;
            ir_ilgl    <= i_ilgl;
            ir_rs1_ren <= i_rs1_ren;
            ir_rs2_ren <= i_rs2_ren;
            ir_opb     <= i_opb;
            ir_usele   <= i_usele;
            ir_rs1     <= i_rs1_idx;
            ir_rs2     <= i_rs2_idx;
            ir_rd      <= i_rd_idx;
            ir_im      <= i_im;
            ir_pc      <= i_pc;
        end else if (fire | discard | take_trap) begin
            ir_vld <= 1'b0;
        end
    end

    // scoreboard: set is applied after clear so a same-index collision sets
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (fire && rd_wen && (ir_rd != 5'd0))
            sb_set = 32'd1 << ir_rd;
        if (i_wb_valid && (i_wb_rd_idx != 5'd0))
            sb_clr = 32'd1 << i_wb_rd_idx;
        sb_nxt    = (sb & ~sb_clr) | sb_set;
        sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sb <= '0;
        else
            sb <= sb_nxt;
    end

    assign o_dec_ready   = dec_ready;
    assign o_iss_valid   = iss_valid;
    assign o_iss_sele    = ir_usele;
    assign o_iss_opb     = ir_opb;
    assign o_iss_rs1_idx = ir_rs1;
    assign o_iss_rs2_idx = ir_rs2;
    assign o_iss_rd_idx  = ir_rd;
    assign o_iss_im      = ir_im;
    assign o_iss_pc      = ir_pc;
    assign o_trap        = trap_q;
    assign o_busy        = ir_vld | in_trap;

endmodule

// File: tb/tb_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_issue_ctrl
//
// Purpose: self-checking bench for issue_ctrl. A behavioural model (issue
// slot as a record, scoreboard as a bit array, trap as a flag) predicts every
// visible output each cycle. Directed scenarios cover the load-use stall,
// back-to-back issue, unit back-pressure, illegal trap, flush and the
// set-wins scoreboard collision; then a long randomized run.
// -----------------------------------------------------------------------------

`ifndef CIRNO_DEC_OPB_SIZE
`define CIRNO_DEC_OPB_SIZE 6
`endif
`ifndef CIRNO_DEC_USELE
`define CIRNO_DEC_USELE 3
`endif
`ifndef CIRNO_DEC_ALU
`define CIRNO_DEC_ALU 0
`endif
`ifndef CIRNO_DEC_BJU
`define CIRNO_DEC_BJU 1
`endif
`ifndef CIRNO_DEC_LSU
`define CIRNO_DEC_LSU 2
`endif
`ifndef CIRNO_DEC_LSU_SB
`define CIRNO_DEC_LSU_SB 0
`endif
`ifndef CIRNO_DEC_LSU_SH
`define CIRNO_DEC_LSU_SH 1
`endif
`ifndef CIRNO_DEC_LSU_SW
`define CIRNO_DEC_LSU_SW 2
`endif
`ifndef CIRNO_DEC_BJU_JAL
`define CIRNO_DEC_BJU_JAL 3
`endif
`ifndef CIRNO_DEC_BJU_JALR
`define CIRNO_DEC_BJU_JALR 4
`endif
`ifndef CIRNO_DEC_BJU_AUIP
`define CIRNO_DEC_BJU_AUIP 5
`endif

module tb_issue_ctrl;

    localparam int OPB_W  = `CIRNO_DEC_OPB_SIZE;
    localparam int SELE_W = `CIRNO_DEC_USELE;
    localparam logic [SELE_W-1:0] U_ALU = SELE_W'(1) << `CIRNO_DEC_ALU;
    localparam logic [SELE_W-1:0] U_BJU = SELE_W'(1) << `CIRNO_DEC_BJU;
    localparam logic [SELE_W-1:0] U_LSU = SELE_W'(1) << `CIRNO_DEC_LSU;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dec_valid;
    logic              dec_ready;
    logic [OPB_W-1:0]  opb;
    logic [SELE_W-1:0] usele;
    logic              rs1_ren, rs2_ren;
    logic [4:0]        rs1_idx, rs2_idx, rd_idx;
    logic [31:0]       im, pc;
    logic              ilgl;
    logic              iss_valid;
    logic [SELE_W-1:0] iss_sele;
    logic [OPB_W-1:0]  iss_opb;
    logic [4:0]        iss_rs1, iss_rs2, iss_rd;
    logic [31:0]       iss_im, iss_pc;
    logic              alu_ready, bju_ready, lsu_ready;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic              flush;
    logic              trap;
    logic              trap_ack;
    logic              busy;

    issue_ctrl #(.OPB_W(OPB_W), .SELE_W(SELE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_dec_valid(dec_valid), .o_dec_ready(dec_ready),
        .i_opb(opb), .i_usele(usele),
        .i_rs1_ren(rs1_ren), .i_rs2_ren(rs2_ren),
        .i_rs1_idx(rs1_idx), .i_rs2_idx(rs2_idx), .i_rd_idx(rd_idx),
        .i_im(im), .i_pc(pc), .i_ilgl(ilgl),
        .o_iss_valid(iss_valid), .o_iss_sele(iss_sele), .o_iss_opb(iss_opb),
        .o_iss_rs1_idx(iss_rs1), .o_iss_rs2_idx(iss_rs2), .o_iss_rd_idx(iss_rd),
        .o_iss_im(iss_im), .o_iss_pc(iss_pc),
        .i_alu_ready(alu_ready), .i_bju_ready(bju_ready), .i_lsu_ready(lsu_ready),
        .i_wb_valid(wb_valid), .i_wb_rd_idx(wb_rd),
        .i_flush(flush), .o_trap(trap), .i_trap_ack(trap_ack), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit              full;
        bit              ilgl;
        bit              r1en, r2en;
        bit [OPB_W-1:0]  opb;
        bit [SELE_W-1:0] sele;
        bit [4:0]        rs1, rs2, rd;
        bit [31:0]       im, pc;
    } slot_t;

    slot_t m_ir;
    bit    m_sb[32];
    bit    m_trap_wait;
    bit    m_pulse;

    function automatic bit writes_rd(input bit [SELE_W-1:0] s, input bit [OPB_W-1:0] o);
        bit w = 0;
        if (s[`CIRNO_DEC_ALU]) w = 1;
        if (s[`CIRNO_DEC_LSU] && !(o[`CIRNO_DEC_LSU_SB] || o[`CIRNO_DEC_LSU_SH] || o[`CIRNO_DEC_LSU_SW])) w = 1;
        if (s[`CIRNO_DEC_BJU] && (o[`CIRNO_DEC_BJU_JAL] || o[`CIRNO_DEC_BJU_JALR] || o[`CIRNO_DEC_BJU_AUIP])) w = 1;
        return w;
    endfunction

    function automatic logic [31:0] sb_word();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_sb[i];
        return v;
    endfunction

    task automatic model_reset();
        m_ir        = '{default: 0};
        m_trap_wait = 0;
        m_pulse     = 0;
        for (int i = 0; i < 32; i++) m_sb[i] = 0;
    endtask

    // One clock: predict and compare at the falling edge, advance the model,
    // then return just after the rising edge for the next stimulus.
    task automatic step();
        bit wen, blocked, e_valid, unit_rdy, e_fire, e_ready;
        @(negedge clk);
        wen     = writes_rd(m_ir.sele, m_ir.opb);
        blocked = (m_ir.r1en && m_sb[m_ir.rs1]) || (m_ir.r2en && m_sb[m_ir.rs2]) || (wen && m_sb[m_ir.rd]);
        e_valid = m_ir.full && !m_ir.ilgl && !blocked && !m_trap_wait && !flush && (m_ir.sele != 0);
        unit_rdy = (m_ir.sele == U_ALU && alu_ready) || (m_ir.sele == U_BJU && bju_ready)
                || (m_ir.sele == U_LSU && lsu_ready);
        e_fire  = e_valid && unit_rdy;
        e_ready = !m_trap_wait && !flush && (!m_ir.full || e_fire);

        chk("iss_valid", iss_valid, e_valid);
        chk("dec_ready", dec_ready, e_ready);
        chk("trap",      trap, m_pulse);
        chk("busy",      busy, m_ir.full || m_trap_wait);
        chk("iss_ctl",   {iss_sele, iss_opb, iss_rs1, iss_rs2, iss_rd},
                         {m_ir.sele, m_ir.opb, m_ir.rs1, m_ir.rs2, m_ir.rd});
        chk("iss_data",  {iss_im, iss_pc}, {m_ir.im, m_ir.pc});
        chk("scoreboard", dut.sb, sb_word());

        if (wb_valid && wb_rd != 0) m_sb[wb_rd] = 0;
        if (e_fire && wen && m_ir.rd != 0) m_sb[m_ir.rd] = 1;

        m_pulse = 0;
        if (flush) begin
            m_ir.full   = 0;
            m_trap_wait = 0;
        end else if (m_trap_wait) begin
            if (trap_ack) m_trap_wait = 0;
        end else if (m_ir.full && m_ir.ilgl) begin
            m_ir.full   = 0;
            m_trap_wait = 1;
            m_pulse     = 1;
        end else if (dec_valid && e_ready) begin
            m_ir = '{full: 1, ilgl: ilgl, r1en: rs1_ren, r2en: rs2_ren, opb: opb, sele: usele,
                     rs1: rs1_idx, rs2: rs2_idx, rd: rd_idx, im: im, pc: pc};
        end else if (e_fire || (m_ir.full && m_ir.sele == 0)) begin
            m_ir.full = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        dec_valid = 0; opb = '0; usele = '0; rs1_ren = 0; rs2_ren = 0;
        rs1_idx = 0; rs2_idx = 0; rd_idx = 0; im = 0; pc = 0; ilgl = 0;
        alu_ready = 1; bju_ready = 1; lsu_ready = 1;
        wb_valid = 0; wb_rd = 0; flush = 0; trap_ack = 0;
    endtask

    task automatic dec(input logic [SELE_W-1:0] s, input logic [OPB_W-1:0] o,
                       input logic r1en, input logic [4:0] r1,
                       input logic r2en, input logic [4:0] r2,
                       input logic [4:0] rd, input logic il);
        dec_valid = 1; usele = s; opb = o; rs1_ren = r1en; rs1_idx = r1;
        rs2_ren = r2en; rs2_idx = r2; rd_idx = rd; ilgl = il;
        im = $urandom; pc = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        #1;
        model_reset();
        chk("rst_busy",      busy, 1'b0);
        chk("rst_iss_valid", iss_valid, 1'b0);
        chk("rst_trap",      trap, 1'b0);
        chk("rst_sb",        dut.sb, 32'd0);
        chk("rst_data",      {iss_im, iss_pc, iss_rd}, '0);
        @(posedge clk);
        #2 rst_n = 1;
    endtask

    task automatic random_inputs();
        int r;
        dec_valid = ($urandom_range(0, 3) != 0);
        opb       = OPB_W'($urandom);
        r         = $urandom_range(0, 15);
        usele     = (r == 0) ? '0 : (SELE_W'(1) << (r % 3));
        ilgl      = ($urandom_range(0, 15) == 0);
        rs1_ren   = $urandom_range(0, 1);
        rs2_ren   = $urandom_range(0, 1);
        rs1_idx   = 5'($urandom_range(0, 7));
        rs2_idx   = 5'($urandom_range(0, 7));
        rd_idx    = 5'($urandom_range(0, 7));
        im        = $urandom;
        pc        = $urandom;
        alu_ready = ($urandom_range(0, 3) != 0);
        bju_ready = ($urandom_range(0, 3) != 0);
        lsu_ready = ($urandom_range(0, 3) != 0);
        wb_valid  = ($urandom_range(0, 2) == 0);
        wb_rd     = 5'($urandom_range(0, 7));
        flush     = ($urandom_range(0, 24) == 0);
        trap_ack  = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        do_reset();

        // load-use: lw x5 ; add x6,x5,x1 ; writeback x5 releases the add
        dec(U_LSU, '0, 1, 5'd2, 0, 5'd0, 5'd5, 0); step();
        dec(U_ALU, '0, 1, 5'd5, 1, 5'd1, 5'd6, 0); step();
        idle_inputs(); step(); step();
        wb_valid = 1; wb_rd = 5'd5; step();
        idle_inputs(); step(); step();
        chk("add_sb6", dut.sb[6], 1'b1);

        // back-to-back addi x1..x4
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            dec(U_ALU, '0, 1, 5'd0, 0, 5'd0, 5'(i), 0);
            step();
        end
        idle_inputs(); step(); step();
        chk("b2b_sb", dut.sb[4:1], 4'hF);

        // addi x0 under ALU back-pressure
        do_reset();
        dec(U_ALU, '0, 1, 5'd0, 0, 5'd0, 5'd0, 0); step();
        idle_inputs(); alu_ready = 0; bju_ready = 1; lsu_ready = 1;
        step(); step(); step();
        alu_ready = 1; step(); step();
        chk("x0_sb0", dut.sb[0], 1'b0);

        // illegal instruction: decode keeps offering, trap held until ack
        do_reset();
        dec(U_ALU, '0, 0, 5'd0, 0, 5'd0, 5'd3, 1); step();
        dec(U_ALU, '0, 0, 5'd0, 0, 5'd0, 5'd4, 0);
        step(); step(); step();
        trap_ack = 1; step();
        trap_ack = 0; step(); step();

        // flush while stalled on a hazard
        do_reset();
        dec(U_LSU, '0, 0, 5'd0, 0, 5'd0, 5'd5, 0); step();
        dec(U_ALU, '0, 1, 5'd5, 0, 5'd0, 5'd6, 0); step();
        idle_inputs(); step();
        flush = 1; step();
        flush = 0; step();
        chk("flush_sb5", dut.sb[5], 1'b1);

        // addi x7 fires in the same cycle x7 writes back: set wins
        do_reset();
        dec(U_ALU, '0, 0, 5'd0, 0, 5'd0, 5'd7, 0); step();
        idle_inputs(); wb_valid = 1; wb_rd = 5'd7; step();
        chk("set_wins_sb7", dut.sb[7], 1'b1);
        idle_inputs(); step();

        // unselected unit ready is ignored
        do_reset();
        dec(U_BJU, 6'b001000, 0, 5'd0, 0, 5'd0, 5'd9, 0); step();
        idle_inputs(); bju_ready = 0; step(); step();
        bju_ready = 1; step(); step();

        // randomized run with a mid-operation reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            random_inputs();
            step();
            if (c == 1500) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
